// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared state encoding and frame length helper for bit_serializer
//
// Purpose: state_t encoding shared with the downstream detector's debug style,
//          and frame_len() giving the number of serial cycles per accepted word.
// Optional feature macro: SER_PARITY_EN (adds one even-parity bit per frame).

package ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } state_t;

  // Serial cycles per word: the data bits, plus the parity bit when enabled.
  function automatic int frame_len(input int width);
`ifdef SER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel word to MSB-first serial bit stream
//
// Purpose: accepts WIDTH-bit words on a valid/ready handshake and shifts them
//          out one bit per clock, optionally followed by GAP_CYCLES idle cycles.
// Optional feature macro: SER_PARITY_EN - appends an even-parity bit (XOR of
//          the word) after the LSB; frames become WIDTH+1 cycles.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   data_in    in   [WIDTH-1:0] word to serialize
//   data_valid in   data_in valid
//   data_ready out  word can be accepted this cycle
//   serial_bit out  current serial bit (0 when bit_valid=0)
//   bit_valid  out  serial_bit is meaningful
//   word_done  out  high during the final bit cycle of a frame
//   state      out  [1:0] FSM state (debug)

module bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_bit,
  output logic             bit_valid,
  output logic             word_done,
  output logic [1:0]       state
);

  localparam int FLEN = frame_len(WIDTH);

  // Counters are sized to hold their terminal value and never run past it.
  localparam int BC_W = (FLEN > 2) ? $clog2(FLEN) : 1;
  localparam int GC_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(FLEN - 1);
  localparam logic [GC_W-1:0] GC_LAST = GC_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           st;
  logic [WIDTH-1:0] shift_reg;
  logic [BC_W-1:0]  bit_cnt;
  logic [GC_W-1:0]  gap_cnt;
  logic             last_bit;
  logic             take;
  logic             cur_bit;

`ifdef SER_PARITY_EN
  logic parity_reg;

  // The final frame cycle carries the stored parity instead of the
  // (by then zero-filled) shift register MSB.
  assign cur_bit = (bit_cnt == BC_LAST) ? parity_reg : shift_reg[WIDTH-1];
`else
  assign cur_bit = shift_reg[WIDTH-1];
`endif

  assign last_bit = (st == SHIFT) && (bit_cnt == BC_LAST);

  // Ready in IDLE, and in the last bit cycle only for a continuous stream so
  // the next word follows without a bubble. Held low throughout reset.
  assign data_ready = reset && ((st == IDLE) || (last_bit && (GAP_CYCLES == 0)));
  assign take       = data_valid && data_ready;

  assign bit_valid  = (st == SHIFT);
  assign serial_bit = bit_valid && cur_bit;
  assign word_done  = last_bit;
  assign state      = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
`ifdef SER_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      case (st)
        IDLE: begin
          if (take) begin
            shift_reg <= data_in;
            bit_cnt   <= '0;
`ifdef SER_PARITY_EN
            parity_reg <= ^data_in;
`endif
            st        <= SHIFT;
          end
        end

        SHIFT: begin
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          if (bit_cnt == BC_LAST) begin
            bit_cnt <= '0;
            if (GAP_CYCLES == 0) begin
              if (take) begin
                // Back-to-back reload overrides the shift above.
                shift_reg <= data_in;
`ifdef SER_PARITY_EN
                parity_reg <= ^data_in;
`endif
              end else begin
                st <= IDLE;
              end
            end else begin
              st      <= GAP;
              gap_cnt <= '0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        GAP: begin
          if (gap_cnt == GC_LAST) begin
            gap_cnt <= '0;
            st      <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - scoreboard bench for bit_serializer (GAP 0 and GAP 2 instances)

module tb_bit_serializer;

  localparam int GAP1 = 2;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] dv;
  logic [3:0] din [2];
  logic [1:0] rdy;
  logic [1:0] sbit;
  logic [1:0] bval;
  logic [1:0] wdone;
  logic [3:0] st_all;

  exp_t q0[$];
  exp_t q1[$];
  int   checks;
  int   passes;
  int   gap_run [2];

  bit_serializer #(.WIDTH(4), .GAP_CYCLES(0)) u_ser0 (
    .clk(clk), .reset(rst_n), .data_in(din[0]), .data_valid(dv[0]),
    .data_ready(rdy[0]), .serial_bit(sbit[0]), .bit_valid(bval[0]),
    .word_done(wdone[0]), .state(st_all[1:0])
  );

  bit_serializer #(.WIDTH(4), .GAP_CYCLES(GAP1)) u_ser1 (
    .clk(clk), .reset(rst_n), .data_in(din[1]), .data_valid(dv[1]),
    .data_ready(rdy[1]), .serial_bit(sbit[1]), .bit_valid(bval[1]),
    .word_done(wdone[1]), .state(st_all[3:2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string name, input int i,
                                input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : GAP1;
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  // Reference model: a frame is the word MSB first, then its even parity when enabled.
  function automatic void push_word(input int i, input logic [3:0] w);
    logic [4:0] frame;
    int n;
`ifdef SER_PARITY_EN
    frame = {w, ^w};
    n = 5;
`else
    frame = {1'b0, w};
    n = 4;
`endif
    for (int k = n - 1; k >= 0; k--) begin
      exp_t e;
      e.b    = frame[k];
      e.last = (k == 0);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endfunction

  function automatic exp_t pop(input int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Monitor: compares every DUT cycle against the scoreboard and the handshake rules.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [1:0] s;
      exp_t e;
      s = st_all[2*i +: 2];
      if (!rst_n) begin
        check("reset_outputs", i, {2'b0, rdy[i], bval[i], sbit[i], wdone[i], s}, 8'h00);
        gap_run[i] = 0;
      end else if (bval[i]) begin
        check("shift_state", i, {6'b0, s}, 8'h01);
        if (qsize(i) == 0) begin
          check("extra_bit", i, 8'h01, 8'h00);
        end else begin
          e = pop(i);
          check("serial_bit", i, {7'b0, sbit[i]}, {7'b0, e.b});
          check("word_done", i, {7'b0, wdone[i]}, {7'b0, e.last});
          check("ready_in_shift", i, {7'b0, rdy[i]}, {7'b0, e.last && (gap_of(i) == 0)});
        end
      end else begin
        check("idle_outputs", i, {6'b0, sbit[i], wdone[i]}, 8'h00);
        check("bubble", i, {7'b0, qsize(i) != 0}, 8'h00);
        if (s == 2'b10) begin
          check("ready_in_gap", i, {7'b0, rdy[i]}, 8'h00);
          gap_run[i]++;
        end else begin
          check("idle_state", i, {6'b0, s}, 8'h00);
          check("ready_in_idle", i, {7'b0, rdy[i]}, 8'h01);
          if (gap_run[i] != 0) begin
            check("gap_len", i, 8'(gap_run[i]), 8'(gap_of(i)));
            gap_run[i] = 0;
          end
        end
      end
    end
  end

  // Called just after a falling edge; returns just after the falling edge that
  // follows the accepting rising edge, with data_valid still high.
  task automatic send(input int i, input logic [3:0] w, input bit scramble);
    dv[i]  = 1'b1;
    din[i] = w;
    for (int t = 0; t < 100; t++) begin
      #4;
      if (rdy[i]) begin
        push_word(i, din[i]);
        @(negedge clk);
        return;
      end
      @(negedge clk);
      if (scramble) din[i] = 4'($urandom);
    end
    check("accept_timeout", i, 8'h00, 8'h01);
  endtask

  task automatic idle(input int i, input int n);
    dv[i]  = 1'b0;
    din[i] = 4'($urandom);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int i);
    bit done;
    done  = 1'b0;
    dv[i] = 1'b0;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      #1;
      if (qsize(i) == 0 && st_all[2*i +: 2] == 2'b00) done = 1'b1;
    end
    check("drain", i, {7'b0, done}, 8'h01);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    gap_run[0] = 0;
    gap_run[1] = 0;
    rst_n  = 1'b0;
    dv     = 2'b00;
    din[0] = 4'h0;
    din[1] = 4'h0;

    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single word, continuous instance.
    send(0, 4'b1001, 1'b0);
    drain(0);

    // Back-to-back with data_valid held.
    send(0, 4'b1001, 1'b0);
    send(0, 4'b0110, 1'b0);
    drain(0);

    // Gapped instance, valid held through SHIFT and GAP.
    send(1, 4'b1001, 1'b0);
    send(1, 4'b0110, 1'b0);
    drain(1);

    // Reset in the middle of a word: outputs clear immediately, no residue.
    send(0, 4'b1011, 1'b0);
    dv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    check("async_reset", 0, {2'b0, rdy[0], bval[0], sbit[0], wdone[0], st_all[1:0]}, 8'h00);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send(0, 4'b0001, 1'b0);
    drain(0);

    // Randomized traffic on both instances, data changing while not ready.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 2) == 0) idle(i, $urandom_range(1, 3));
        send(i, 4'($urandom), 1'($urandom_range(0, 1)));
      end
      drain(i);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
